// File: rtl/stepper_pkg.sv
// Shared types and default widths for the multi-axis stepper.
// State encoding for the move FSM plus default counter widths.
package stepper_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int DEF_CNT_W = 16;
   localparam int DEF_DIV_W = 20;
   localparam int DEF_POS_W = 24;

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: phase/step counters, step_clk, position, finished.
// Ports: load/run/kill/clear from top FSM; steps/half_period/dir in;
// step_clk, finished and signed position out.
module stepper_axis
   import stepper_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int DIV_W = DEF_DIV_W,
   parameter int POS_W = DEF_POS_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             run,
   input  logic             kill,
   input  logic             clear,
   input  logic             dir,
   input  logic [CNT_W-1:0] steps,
   input  logic [DIV_W-1:0] half_period,
   output logic             step_clk,
   output logic             finished,
   output logic [POS_W-1:0] position
);

   logic [DIV_W-1:0] hp;
   logic [DIV_W-1:0] cnt;
   logic [CNT_W-1:0] left;

   logic             nxt_clk;
   logic [DIV_W-1:0] nxt_cnt;
   logic [CNT_W-1:0] nxt_left;
   logic             nxt_fin;
   logic             rise;

   // cnt = cycles remaining in the current phase after this one.
   // Load leaves cnt=0 with step_clk low, so the first rise is
   // one cycle after the accept.
   always_comb begin
      nxt_clk  = step_clk;
      nxt_cnt  = cnt;
      nxt_left = left;
      rise     = 1'b0;
      if (cnt != '0) begin
         nxt_cnt = cnt - DIV_W'(1);
      end else if (step_clk) begin
         nxt_clk = 1'b0;
         nxt_cnt = hp - DIV_W'(1);
      end else if (left != '0) begin
         nxt_clk  = 1'b1;
         nxt_cnt  = hp - DIV_W'(1);
         nxt_left = left - CNT_W'(1);
         rise     = 1'b1;
      end
      // Finished during the last low cycle of the last step.
      nxt_fin = !nxt_clk && (nxt_cnt == '0) && (nxt_left == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hp       <= '0;
         cnt      <= '0;
         left     <= '0;
         step_clk <= 1'b0;
         finished <= 1'b0;
         position <= '0;
      end else begin
         if (clear) begin
            position <= '0;
         end
         if (load) begin
            hp       <= (half_period == '0) ? DIV_W'(1) : half_period;
            cnt      <= '0;
            left     <= steps;
            step_clk <= 1'b0;
            finished <= (steps == '0);
         end else if (kill) begin
            cnt      <= '0;
            left     <= '0;
            step_clk <= 1'b0;
            finished <= 1'b1;
         end else if (run && !finished) begin
            step_clk <= nxt_clk;
            cnt      <= nxt_cnt;
            left     <= nxt_left;
            finished <= nxt_fin;
            if (rise) begin
               position <= dir ? position + POS_W'(1)
                               : position - POS_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/multi_axis_stepper.sv
// N-axis coordinated stepper: move FSM, per-axis generators, packing.
// Ports: cmd handshake/fields, enable/abort/pos_clear controls;
// step_clk/dir pins, busy/done/aborted status, packed positions.
module multi_axis_stepper
   import stepper_pkg::*;
#(
   parameter int N_AXES = 2,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int DIV_W  = DEF_DIV_W,
   parameter int POS_W  = DEF_POS_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [N_AXES*CNT_W-1:0] cmd_steps,
   input  logic [N_AXES-1:0]       cmd_dir,
   input  logic [N_AXES*DIV_W-1:0] cmd_half_period,
   input  logic                    enable,
   input  logic                    abort,
   input  logic                    pos_clear,
   output logic [N_AXES-1:0]       step_clk,
   output logic [N_AXES-1:0]       dir,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic [N_AXES*POS_W-1:0] position
);

   state_t            state;
   logic [N_AXES-1:0] fin;
   logic              all_fin;
   logic              load;
   logic              run;
   logic              kill;
   logic              clear;

   assign cmd_ready = (state == IDLE);
   assign all_fin   = &fin;
   assign load      = cmd_valid && (state == IDLE);
   assign clear     = pos_clear && (state == IDLE);
   // Abort outranks enable: a paused move can still be killed.
   assign kill      = abort && (state == RUN);
   assign run       = enable && !abort && (state == RUN);

   for (genvar g = 0; g < N_AXES; g++) begin : g_axis
      stepper_axis #(
         .CNT_W(CNT_W),
         .DIV_W(DIV_W),
         .POS_W(POS_W)
      ) u_axis (
         .clk        (clk),
         .reset      (reset),
         .load       (load),
         .run        (run),
         .kill       (kill),
         .clear      (clear),
         .dir        (dir[g]),
         .steps      (cmd_steps[g*CNT_W +: CNT_W]),
         .half_period(cmd_half_period[g*DIV_W +: DIV_W]),
         .step_clk   (step_clk[g]),
         .finished   (fin[g]),
         .position   (position[g*POS_W +: POS_W])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         dir     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  dir   <= cmd_dir;
               end
            end
            RUN: begin
               if (abort || all_fin) begin
                  state   <= FINISH;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= abort;
               end
            end
            FINISH: begin
               state   <= IDLE;
               done    <= 1'b0;
               aborted <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_axis_stepper.sv
// Self-checking bench for multi_axis_stepper.
// Reference model works in elapsed enabled RUN cycles per move.
module tb_multi_axis_stepper;

   localparam int N     = 2;
   localparam int CNT_W = 16;
   localparam int DIV_W = 20;
   localparam int POS_W = 8;

   logic               clk;
   logic               rst_n;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [N*CNT_W-1:0] cmd_steps;
   logic [N-1:0]       cmd_dir;
   logic [N*DIV_W-1:0] cmd_half_period;
   logic               enable;
   logic               abort;
   logic               pos_clear;
   logic [N-1:0]       step_clk;
   logic [N-1:0]       dir;
   logic               busy;
   logic               done;
   logic               aborted;
   logic [N*POS_W-1:0] position;

   multi_axis_stepper #(
      .N_AXES(N),
      .CNT_W (CNT_W),
      .DIV_W (DIV_W),
      .POS_W (POS_W)
   ) dut (
      .clk            (clk),
      .reset          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_steps      (cmd_steps),
      .cmd_dir        (cmd_dir),
      .cmd_half_period(cmd_half_period),
      .enable         (enable),
      .abort          (abort),
      .pos_clear      (pos_clear),
      .step_clk       (step_clk),
      .dir            (dir),
      .busy           (busy),
      .done           (done),
      .aborted        (aborted),
      .position       (position)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   logic chk_on   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Model: 0 idle, 1 moving, 2 finishing; k = enabled RUN cycles.
   int                m_st = 0;
   longint            m_k  = 0;
   longint            m_s [N];
   longint            m_h [N];
   logic [N-1:0]      m_dir = '0;
   logic [POS_W-1:0]  m_pos [N];
   logic              m_ab = 1'b0;

   function automatic longint total_cycles();
      longint t = 0;
      for (int i = 0; i < N; i++)
         if (2 * m_s[i] * m_h[i] > t) t = 2 * m_s[i] * m_h[i];
      return t;
   endfunction

   function automatic logic exp_clk(int i);
      if (m_st != 1 || m_k < 1 || m_k > 2 * m_s[i] * m_h[i]) return 1'b0;
      return ((m_k - 1) % (2 * m_h[i])) < m_h[i];
   endfunction

   initial begin
      for (int i = 0; i < N; i++) begin
         m_s[i] = 0; m_h[i] = 1; m_pos[i] = '0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_st = 0; m_k = 0; m_dir = '0; m_ab = 1'b0;
            for (int i = 0; i < N; i++) m_pos[i] = '0;
         end else begin
            case (m_st)
               0: begin
                  if (pos_clear)
                     for (int i = 0; i < N; i++) m_pos[i] = '0;
                  if (cmd_valid) begin
                     for (int i = 0; i < N; i++) begin
                        m_s[i] = longint'(cmd_steps[i*CNT_W +: CNT_W]);
                        m_h[i] = longint'(cmd_half_period[i*DIV_W +: DIV_W]);
                        if (m_h[i] == 0) m_h[i] = 1;
                     end
                     m_dir = cmd_dir;
                     m_k   = 0;
                     m_st  = 1;
                  end
               end
               1: begin
                  if (abort) begin
                     m_st = 2; m_ab = 1'b1;
                  end else if (m_k >= total_cycles()) begin
                     m_st = 2; m_ab = 1'b0;
                  end else if (enable) begin
                     m_k++;
                     for (int i = 0; i < N; i++)
                        if (m_k <= 2 * m_s[i] * m_h[i] &&
                            (m_k - 1) % (2 * m_h[i]) == 0)
                           m_pos[i] = m_dir[i] ? m_pos[i] + 1'b1
                                               : m_pos[i] - 1'b1;
                  end
               end
               default: begin
                  m_st = 0; m_ab = 1'b0;
               end
            endcase
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("cmd_ready", cmd_ready, m_st == 0);
         chk("busy", busy, m_st == 1);
         chk("done", done, m_st == 2);
         chk("aborted", aborted, (m_st == 2) && m_ab);
         chk("dir", dir, m_dir);
         for (int i = 0; i < N; i++) begin
            chk($sformatf("step_clk%0d", i), step_clk[i], exp_clk(i));
            chk($sformatf("position%0d", i),
                position[i*POS_W +: POS_W], m_pos[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int s0, input int h0, input int s1,
                        input int h1, input logic [1:0] d);
      cmd_steps       = {CNT_W'(s1), CNT_W'(s0)};
      cmd_half_period = {DIV_W'(h1), DIV_W'(h0)};
      cmd_dir         = d;
      cmd_valid       = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int start, output int lat);
      int n = start;
      lat = -1;
      while (n < 400) begin
         if (done === 1'b1) begin
            lat = n;
            break;
         end
         tick();
         n++;
      end
      if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [POS_W-1:0] pos(int i);
      return position[i*POS_W +: POS_W];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   int lat;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = '0;
      cmd_half_period = '0; enable = 1'b1; abort = 1'b0;
      pos_clear = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pos", position, '0);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      tick();

      // Basic two-axis move, mixed directions.
      pos_clear = 1'b1; tick(); pos_clear = 1'b0;
      issue(3, 2, 1, 5, 2'b01);
      wait_done(0, lat);
      chk("t1_lat", lat, 13);
      chk("t1_pos0", pos(0), 8'd3);
      chk("t1_pos1", pos(1), 8'hFF);
      chk("t1_ab", aborted, 1'b0);
      tick();

      // All-zero command.
      issue(0, 7, 0, 0, 2'b11);
      wait_done(0, lat);
      chk("t2_lat", lat, 1);
      chk("t2_ab", aborted, 1'b0);
      tick();
      chk("t2_pos0", pos(0), 8'd3);
      chk("t2_pos1", pos(1), 8'hFF);

      // Pause for 3 cycles; stray cmd_valid mid-move is ignored.
      issue(4, 1, 2, 2, 2'b11);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();
      enable = 1'b0;
      tick(); tick(); tick();
      enable = 1'b1;
      wait_done(6, lat);
      chk("t3_lat", lat, 12);
      chk("t3_pos0", pos(0), 8'd7);
      chk("t3_pos1", pos(1), 8'd1);
      tick();

      // Abort in IDLE is ignored, then abort mid-move.
      abort = 1'b1; tick(); abort = 1'b0;
      issue(10, 3, 0, 0, 2'b01);
      repeat (7) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_done", done, 1'b1);
      chk("t4_ab", aborted, 1'b1);
      chk("t4_clk", step_clk, 2'b00);
      chk("t4_pos0", pos(0), 8'd9);
      tick();
      chk("t4_ready", cmd_ready, 1'b1);

      // Wrap positive to most negative.
      pos_clear = 1'b1; tick(); pos_clear = 1'b0;
      issue(127, 1, 0, 0, 2'b01);
      wait_done(0, lat);
      chk("t5_lat", lat, 255);
      chk("t5_max", pos(0), 8'h7F);
      tick();
      issue(1, 1, 0, 0, 2'b01);
      wait_done(0, lat);
      chk("t5_wrap", pos(0), 8'h80);
      tick();

      // pos_clear ignored in RUN.
      issue(2, 1, 1, 1, 2'b00);
      tick();
      pos_clear = 1'b1;
      tick(); tick();
      pos_clear = 1'b0;
      wait_done(3, lat);
      chk("t6_lat", lat, 5);
      chk("t6_pos0", pos(0), 8'h7E);
      chk("t6_pos1", pos(1), 8'hFF);
      tick();

      // pos_clear and accept in the same cycle.
      pos_clear = 1'b1;
      issue(1, 1, 0, 0, 2'b01);
      pos_clear = 1'b0;
      wait_done(0, lat);
      chk("t7_lat", lat, 3);
      chk("t7_pos0", pos(0), 8'd1);
      chk("t7_pos1", pos(1), 8'd0);
      tick();

      // Asynchronous reset mid-move.
      issue(10, 3, 0, 0, 2'b01);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("t8_busy", busy, 1'b0);
      chk("t8_clk", step_clk, 2'b00);
      chk("t8_pos", position, '0);
      chk("t8_ready", cmd_ready, 1'b1);
      chk("t8_dir", dir, 2'b00);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t8_ready2", cmd_ready, 1'b1);
      issue(2, 2, 1, 1, 2'b11);
      wait_done(0, lat);
      chk("t8_lat", lat, 9);
      chk("t8_pos0", pos(0), 8'd2);
      chk("t8_pos1", pos(1), 8'd1);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
